// File: rtl/credit_sender_pkg.sv
// Shared helpers for credit-based push senders and their counters.
package credit_sender_pkg;

  // Bits needed to represent every value in 0..n (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Credit counter: loads MAX on reset, takes one credit per dec, adds up to RET_MAX
// returned credits per cycle, saturates at MAX and flags overflow until reset.
module credit_counter
  import credit_sender_pkg::*;
#(
  parameter int MAX     = 4,
  parameter int RET_MAX = 1,
  localparam int CW     = cnt_w(MAX),
  localparam int RW     = cnt_w(RET_MAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dec,
  input  logic [RW-1:0] inc,
  output logic [CW-1:0] count,
  output logic          err
);

  // Wide enough for count + inc before saturation, so the sum never wraps.
  localparam int NW = cnt_w(MAX + RET_MAX);
  localparam logic [NW-1:0] MAX_N = NW'(MAX);

  logic [NW-1:0] sum_p0;
  logic          ovf_p0;
  logic          unf_p0;

  function automatic logic [CW-1:0] sat(input logic [NW-1:0] v);
    return (v > MAX_N) ? CW'(MAX) : v[CW-1:0];
  endfunction

  assign sum_p0 = NW'(count) + NW'(inc) - NW'(dec);
  assign ovf_p0 = (sum_p0 > MAX_N);
  assign unf_p0 = dec && (count == '0);

  // p0 -> p1: count register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= CW'(MAX);
      err   <= 1'b0;
    end else begin
      count <= sat(sum_p0);
      err   <= err | ovf_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!ovf_p0) else $warning("credit_counter: credit overflow, count saturated");
      assert (!unf_p0) else $error("credit_counter: credit underflow");
    end
  end

endmodule

// File: rtl/credit_sender.sv
// Producer side of a credit-based push channel: accepts valid/ready traffic and
// pushes it to a remote buffer only while it holds a credit for a free entry.
module credit_sender
  import credit_sender_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CREDITS = 4,
  parameter int RET_MAX = 1,
  parameter int REG_OUT = 1,
  localparam int CW     = cnt_w(CREDITS),
  localparam int RW     = cnt_w(RET_MAX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IN_valid,
  input  logic [WIDTH-1:0] IN_data,
  output logic             OUT_ready,
  output logic             OUT_valid,
  output logic [WIDTH-1:0] OUT_data,
  input  logic [RW-1:0]    IN_creditRet,
  output logic [CW-1:0]    OUT_credits,
  output logic             OUT_creditErr
);

  logic accept_p0;

  // Ready comes only from the credit register, keeping the upstream path short.
  assign OUT_ready = (OUT_credits != '0);
  assign accept_p0 = IN_valid && OUT_ready;

  credit_counter #(
    .MAX     (CREDITS),
    .RET_MAX (RET_MAX)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .dec   (accept_p0),
    .inc   (IN_creditRet),
    .count (OUT_credits),
    .err   (OUT_creditErr)
  );

  generate
    if (REG_OUT != 0) begin : g_reg
      logic             vld_p1;
      logic [WIDTH-1:0] data_p1;

      // p0 -> p1: registered push; data only loads on accept
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
        end else begin
          vld_p1 <= accept_p0;
          if (accept_p0) data_p1 <= IN_data;
        end
      end

      assign OUT_valid = vld_p1;
      assign OUT_data  = data_p1;
    end else begin : g_comb
      assign OUT_valid = accept_p0;
      assign OUT_data  = IN_data;
    end
  endgenerate

endmodule

// File: tb/tb_credit_sender.sv
// Bench for credit_sender: directed vector table, in-flight reset, and random
// traffic into a depth-4 receiver model popping every other cycle.
module tb_credit_sender;

  localparam int CREDITS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IN_valid;
  logic [31:0] IN_data;
  logic        OUT_ready;
  logic        OUT_valid;
  logic [31:0] OUT_data;
  logic [0:0]  IN_creditRet;
  logic [2:0]  OUT_credits;
  logic        OUT_creditErr;

  logic [0:0]  man_ret;
  logic [0:0]  rx_ret = 1'b0;
  logic        auto_on;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_push = 0;

  // Reference model state: what the DUT must show after the next posedge.
  logic [2:0]  m_cred = 3'd4;
  logic        m_err = 1'b0;
  logic        m_vld = 1'b0;
  logic        phase = 1'b0;
  logic        inv_on = 1'b0;
  logic [0:0]  ret_now;
  logic        acc;
  int          t;
  logic [31:0] sb [$];
  logic [31:0] rx [$];

  typedef struct packed {
    logic       vld;
    logic       ret;
    logic       rdy;
    logic [2:0] cred;
    logic       ov;
    logic       err;
  } vec_t;

  vec_t tv [17];

  assign IN_creditRet = auto_on ? rx_ret : man_ret;

  always #5 clk = ~clk;

  credit_sender #(
    .WIDTH   (32),
    .CREDITS (CREDITS),
    .RET_MAX (1),
    .REG_OUT (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IN_valid      (IN_valid),
    .IN_data       (IN_data),
    .OUT_ready     (OUT_ready),
    .OUT_valid     (OUT_valid),
    .OUT_data      (OUT_data),
    .IN_creditRet  (IN_creditRet),
    .OUT_credits   (OUT_credits),
    .OUT_creditErr (OUT_creditErr)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor, receiver model and scoreboard, all on the inactive edge.
  always @(negedge clk) begin
    chk("mdl_credits", 64'(OUT_credits), 64'(m_cred));
    chk("mdl_ready", 64'(OUT_ready), 64'(m_cred != 3'd0));
    chk("mdl_err", 64'(OUT_creditErr), 64'(m_err));
    chk("mdl_push", 64'(OUT_valid), 64'(m_vld));
    if (OUT_valid) begin
      n_push++;
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) chk("push_data", 64'(OUT_data), 64'(sb.pop_front()));
    end
    if (inv_on) begin
      chk("invariant", 64'(int'(OUT_credits) + int'(OUT_valid) + rx.size()), 64'(CREDITS));
      if (OUT_valid) rx.push_back(OUT_data);
      chk("rx_depth_ok", 64'(rx.size() <= CREDITS), 64'd1);
    end
    if (!rst_n) begin
      m_cred = 3'd4;
      m_err  = 1'b0;
      m_vld  = 1'b0;
      sb.delete();
      rx.delete();
      rx_ret = 1'b0;
      phase  = 1'b0;
      inv_on = 1'b0;
    end else begin
      rx_ret = 1'b0;
      if (auto_on) begin
        phase = !phase;
        if (phase && rx.size() > 0) begin
          rx.delete(0);
          rx_ret = 1'b1;
        end
      end
      ret_now = auto_on ? rx_ret : man_ret;
      acc = IN_valid && (m_cred != 3'd0);
      m_vld = acc;
      if (acc) begin
        sb.push_back(IN_data);
        n_acc++;
      end
      t = int'(m_cred) - int'(acc) + int'(ret_now);
      if (t > CREDITS) begin
        t = CREDITS;
        m_err = 1'b1;
      end
      m_cred = 3'(t);
      inv_on = auto_on;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    //             vld   ret   rdy   cred  ov    err
    tv[0]  = '{1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
    tv[4]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
    tv[8]  = '{1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0};
    tv[9]  = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0};
    tv[10] = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0};
    tv[11] = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0};
    tv[12] = '{1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0};
    tv[13] = '{1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0};
    tv[14] = '{1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0};
    tv[15] = '{1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1};
    tv[16] = '{1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1};

    rst_n    = 1'b0;
    IN_valid = 1'b0;
    IN_data  = '0;
    man_ret  = 1'b0;
    auto_on  = 1'b0;
    tick();
    tick();
    chk("rst_credits", 64'(OUT_credits), 64'd4);
    chk("rst_ready", 64'(OUT_ready), 64'd1);
    chk("rst_valid", 64'(OUT_valid), 64'd0);
    chk("rst_data", 64'(OUT_data), 64'd0);
    chk("rst_err", 64'(OUT_creditErr), 64'd0);

    // Fill, stall at zero, late return, credit-neutral accepts, overflow.
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      IN_valid = tv[i].vld;
      man_ret  = tv[i].ret;
      IN_data  = 32'hA000_0000 + 32'(i);
      tick();
      chk($sformatf("tbl%0d_credits", i), 64'(OUT_credits), 64'(tv[i].cred));
      chk($sformatf("tbl%0d_ready", i), 64'(OUT_ready), 64'(tv[i].rdy));
      chk($sformatf("tbl%0d_valid", i), 64'(OUT_valid), 64'(tv[i].ov));
      chk($sformatf("tbl%0d_err", i), 64'(OUT_creditErr), 64'(tv[i].err));
      if (tv[i].ov) chk($sformatf("tbl%0d_data", i), 64'(OUT_data), 64'(32'hA000_0000 + 32'(i)));
    end

    // Reset while a push is pending and credits are down to 1.
    IN_valid = 1'b1;
    man_ret  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      IN_data = 32'hB000_0000 + 32'(i);
      tick();
    end
    chk("pre_rst_credits", 64'(OUT_credits), 64'd1);
    chk("pre_rst_valid", 64'(OUT_valid), 64'd1);
    chk("pre_rst_err", 64'(OUT_creditErr), 64'd1);
    rst_n   = 1'b0;
    man_ret = 1'b1;
    IN_data = 32'hB000_00FF;
    tick();
    chk("mid_rst_valid", 64'(OUT_valid), 64'd0);
    chk("mid_rst_credits", 64'(OUT_credits), 64'd4);
    chk("mid_rst_err", 64'(OUT_creditErr), 64'd0);
    chk("mid_rst_ready", 64'(OUT_ready), 64'd1);

    // Random traffic into the receiver model.
    IN_valid = 1'b0;
    man_ret  = 1'b0;
    auto_on  = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      IN_valid = ($urandom_range(0, 3) != 0);
      IN_data  = $urandom;
      tick();
    end
    IN_valid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (rx.size() == 0 && OUT_credits == 3'd4 && !OUT_valid) break;
      tick();
    end
    chk("drain_credits", 64'(OUT_credits), 64'd4);
    chk("drain_rx_empty", 64'(rx.size()), 64'd0);
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    chk("accepts_pushed", 64'(n_push), 64'(n_acc));
    chk("drain_err", 64'(OUT_creditErr), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
